mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 51 +++++
 rtl/mem_port_arbiter_lat_counter.sv | 33 +++
 rtl/mem_port_arbiter.sv | 123 ++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and defaults for the single-port memory arbiter.
// Imported by the interface, the latency counter and the top.
package mem_port_arbiter_pkg;

  localparam int ARB_ADDR_W  = 16;
  localparam int ARB_DATA_W  = 16;
  localparam int ARB_MEM_LAT = 2;
  localparam int ARB_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    DONE
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-side bundle of the arbiter.
// master = requesters and memory, slave = arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W
) ();

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_cancel;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic                  dm_ack;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  stop;

  modport master (
    output if_req, if_addr, if_cancel,
    output dm_req, dm_we, dm_addr, dm_wdata,
    output mem_rdata,
    input  if_ack, if_rdata,
    input  dm_ack, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  stop
  );

  modport slave (
    input  if_req, if_addr, if_cancel,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    input  mem_rdata,
    output if_ack, if_rdata,
    output dm_ack, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output stop
  );

endinterface

// File: rtl/mem_port_arbiter_lat_counter.sv
// Memory latency counter: cleared at grant, counts BUSY cycles,
// flags done once it reaches MEM_LAT and then holds.
module arb_lat_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MEM_LAT = ARB_MEM_LAT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic done_o
);

  logic [ARB_CNT_W-1:0] cnt_q;
  logic [ARB_CNT_W-1:0] cnt_d;

  assign done_o = (cnt_q == ARB_CNT_W'(MEM_LAT));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i && !done_o)
      cnt_d = cnt_q + ARB_CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and MEM-stage requests onto one memory port,
// DM-first with alternation when both keep requesting.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ARB_ADDR_W,
  parameter int DATA_WIDTH = ARB_DATA_W,
  parameter int MEM_LAT    = ARB_MEM_LAT
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  arb_state_e            state_q;
  logic                  last_dm_q;
  logic                  cancel_q;
  logic                  we_q;
  logic                  mem_en_q;
  logic                  mem_we_q;
  logic                  if_ack_q;
  logic                  dm_ack_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] if_rdata_q;
  logic [DATA_WIDTH-1:0] dm_rdata_q;

  logic pick_dm;
  logic pick_if;
  logic grant;
  logic busy;
  logic if_kill;
  logic lat_done;
  logic if_ack_w;

  assign pick_dm = bus.dm_req & ~(bus.if_req & last_dm_q);
  assign pick_if = bus.if_req & ~pick_dm;
  assign grant   = (state_q == IDLE) & (pick_dm | pick_if);
  assign busy    = (state_q == BUSY_IF) | (state_q == BUSY_DM);
  assign if_kill = cancel_q | bus.if_cancel;

  arb_lat_counter #(
    .MEM_LAT (MEM_LAT)
  ) u_lat (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (grant),
    .en_i   (busy),
    .done_o (lat_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      last_dm_q  <= 1'b0;
      cancel_q   <= 1'b0;
      we_q       <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      mem_en_q <= 1'b0;
      mem_we_q <= 1'b0;
      if_ack_q <= 1'b0;
      dm_ack_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (grant) begin
            state_q   <= pick_dm ? BUSY_DM : BUSY_IF;
            last_dm_q <= pick_dm;
            addr_q    <= pick_dm ? bus.dm_addr : bus.if_addr;
            wdata_q   <= pick_dm ? bus.dm_wdata : '0;
            we_q      <= pick_dm & bus.dm_we;
            mem_en_q  <= 1'b1;
            mem_we_q  <= pick_dm & bus.dm_we;
          end
        end
        BUSY_IF: begin
          if (bus.if_cancel) cancel_q <= 1'b1;
          if (lat_done) begin
            state_q <= DONE;
            if (!if_kill) begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= bus.mem_rdata;
            end
          end
        end
        BUSY_DM: begin
          if (lat_done) begin
            state_q  <= DONE;
            dm_ack_q <= 1'b1;
            if (!we_q) dm_rdata_q <= bus.mem_rdata;
          end
        end
        DONE: begin
          state_q  <= IDLE;
          cancel_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // A redirect landing in the IF ack cycle still kills that ack.
  assign if_ack_w      = if_ack_q & ~bus.if_cancel;

  assign bus.if_ack    = if_ack_w;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.stop      = (bus.if_req & ~if_ack_w)
                       | (bus.dm_req & ~dm_ack_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed accesses push
// expected acks and memory strobes; negedge monitors pop and compare.
module tb_mem_port_arbiter;

  localparam int LAT = 2;

  typedef struct {
    logic [15:0] data;
    int          due;
  } ack_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } acc_t;

  logic clk;
  logic rst;
  int   cyc;
  int   n_chk;
  int   n_err;

  ack_t dmq[$];
  ack_t ifq[$];
  acc_t memq[$];
  ack_t rdq[$];

  logic [15:0] mem [0:65535];

  mem_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) bus ();

  mem_port_arbiter #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .MEM_LAT    (LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    cyc = 0;
    forever begin
      #5 clk = 1'b1;
      cyc++;
      #5 clk = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_ack"},    32'(bus.if_ack), 0);
    chk({tag, "_dm_ack"},    32'(bus.dm_ack), 0);
    chk({tag, "_mem_en"},    32'(bus.mem_en), 0);
    chk({tag, "_mem_we"},    32'(bus.mem_we), 0);
    chk({tag, "_mem_addr"},  32'(bus.mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 0);
    chk({tag, "_if_rdata"},  32'(bus.if_rdata), 0);
    chk({tag, "_dm_rdata"},  32'(bus.dm_rdata), 0);
  endtask

  // Memory model: read data shows up exactly LAT cycles after mem_en.
  always @(negedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
      else rdq.push_back('{mem[bus.mem_addr], cyc + LAT});
    end
  end

  initial begin
    bus.mem_rdata = 16'hDEAD;
    forever begin
      @(posedge clk);
      #1;
      while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
      if (rdq.size() > 0 && rdq[0].due == cyc)
        bus.mem_rdata = rdq.pop_front().data;
      else
        bus.mem_rdata = 16'hDEAD;
    end
  end

  // Monitors
  always @(negedge clk) begin
    ack_t e;
    acc_t a;
    if (bus.dm_ack) begin
      if (dmq.size() == 0) chk("dm_ack_unexpected", 32'(bus.dm_ack), 0);
      else begin
        e = dmq.pop_front();
        chk("dm_rdata", 32'(bus.dm_rdata), 32'(e.data));
        chk("dm_ack_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (bus.if_ack) begin
      if (ifq.size() == 0) chk("if_ack_unexpected", 32'(bus.if_ack), 0);
      else begin
        e = ifq.pop_front();
        chk("if_rdata", 32'(bus.if_rdata), 32'(e.data));
        chk("if_ack_cycle", 32'(cyc), 32'(e.due));
      end
    end
    if (bus.mem_en || bus.mem_we) begin
      if (memq.size() == 0)
        chk("mem_unexpected", 32'(bus.mem_en | bus.mem_we), 0);
      else begin
        a = memq.pop_front();
        chk("mem_en", 32'(bus.mem_en), 1);
        chk("mem_we", 32'(bus.mem_we), 32'(a.we));
        chk("mem_addr", 32'(bus.mem_addr), 32'(a.addr));
        chk("mem_wdata", 32'(bus.mem_wdata), 32'(a.wdata));
      end
    end
  end

  task automatic dm_acc(input logic we, input logic [15:0] ad,
                        input logic [15:0] wd, input logic [15:0] rd,
                        input int off, input bit pm);
    int t0;
    bit got;
    t0 = cyc;
    bus.dm_req   = 1'b1;
    bus.dm_we    = we;
    bus.dm_addr  = ad;
    bus.dm_wdata = wd;
    dmq.push_back('{rd, t0 + off});
    if (pm) memq.push_back('{we, ad, wd});
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.dm_ack) got = 1'b1;
    end
    chk("dm_ack_seen", 32'(got), 1);
    @(posedge clk);
    #1;
    bus.dm_req = 1'b0;
  endtask

  task automatic if_acc(input logic [15:0] ad, input logic [15:0] rd,
                        input int off);
    int t0;
    bit got;
    t0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = ad;
    ifq.push_back('{rd, t0 + off});
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.if_ack) got = 1'b1;
    end
    chk("if_ack_seen", 32'(got), 1);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
  endtask

  initial begin
    int  t0;
    bit  got;
    n_chk = 0;
    n_err = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem['h0040] = 16'hBEEF;
    mem['h0100] = 16'hC0DE;
    mem['h0200] = 16'h1111;
    mem['h0300] = 16'h2222;
    mem['h0020] = 16'hA5A5;
    mem['h0030] = 16'h5A5A;
    mem['h0050] = 16'h7777;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.if_cancel = 1'b0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;

    repeat (2) @(negedge clk);
    chk_zero("por");
    chk("por_stop", 32'(bus.stop), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // DM read: mem_en in c1, data in c3, ack c4, stop c0..c3
    t0 = cyc;
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0040;
    dmq.push_back('{16'hBEEF, t0 + 4});
    memq.push_back('{1'b0, 16'h0040, 16'h0000});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("rd_stop_c%0d", k), 32'(bus.stop), 1);
      chk($sformatf("rd_mem_en_c%0d", k), 32'(bus.mem_en),
          (k == 1) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("rd_stop_c4", 32'(bus.stop), 0);
    @(posedge clk);
    #1;
    bus.dm_req = 1'b0;

    // DM write keeps dm_rdata at the last read value
    dm_acc(1'b1, 16'h0010, 16'h1234, 16'hBEEF, 4, 1'b1);
    chk("wr_mem_model", 32'(mem['h0010]), 32'h1234);
    chk("wr_dm_rdata_hold", 32'(bus.dm_rdata), 32'hBEEF);

    // Reset, then both requesting from the first post-reset edge
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk_zero("rst2");
    @(posedge clk);
    #1;
    rst = 1'b0;
    memq.push_back('{1'b0, 16'h0020, 16'h0000});
    memq.push_back('{1'b0, 16'h0200, 16'h0000});
    memq.push_back('{1'b0, 16'h0030, 16'h0000});
    memq.push_back('{1'b0, 16'h0300, 16'h0000});
    fork
      begin
        dm_acc(1'b0, 16'h0020, 16'h0000, 16'hA5A5, 4, 1'b0);
        dm_acc(1'b0, 16'h0030, 16'h0000, 16'h5A5A, 9, 1'b0);
      end
      begin
        if_acc(16'h0200, 16'h1111, 9);
        if_acc(16'h0300, 16'h2222, 9);
      end
    join

    // Fetch cancelled in its second BUSY cycle, redirect to 0x0100
    t0 = cyc;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0050;
    memq.push_back('{1'b0, 16'h0050, 16'h0000});
    memq.push_back('{1'b0, 16'h0100, 16'h0000});
    ifq.push_back('{16'hC0DE, t0 + 9});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    bus.if_cancel = 1'b1;
    bus.if_addr   = 16'h0100;
    @(posedge clk);
    #1;
    bus.if_cancel = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("cancel_no_ack", 32'(bus.if_ack), 0);
    chk("cancel_stop", 32'(bus.stop), 1);
    @(negedge clk);
    chk("cancel_rdata_hold", 32'(bus.if_rdata), 32'h2222);
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.if_ack) got = 1'b1;
    end
    chk("redirect_ack_seen", 32'(got), 1);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;

    // Reset in the second BUSY_DM cycle aborts with no ack
    bus.dm_req  = 1'b1;
    bus.dm_we   = 1'b0;
    bus.dm_addr = 16'h0040;
    memq.push_back('{1'b0, 16'h0040, 16'h0000});
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    bus.dm_req = 1'b0;
    #1;
    chk_zero("midrst");
    chk("midrst_stop", 32'(bus.stop), 0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    dm_acc(1'b0, 16'h0020, 16'h0000, 16'hA5A5, 4, 1'b1);

    repeat (4) @(negedge clk);
    chk("dmq_drained", 32'(dmq.size()), 0);
    chk("ifq_drained", 32'(ifq.size()), 0);
    chk("memq_drained", 32'(memq.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
